scope_trigger_capture: RTL
==========================

# scope_trigger_capture

Trigger-and-capture stage sitting directly downstream of the ADC front-end channel block. It consumes the conditioned 14-bit sample stream, keeps a circular record in on-chip RAM, detects a level/edge trigger, and freezes a window of DEPTH samples with a programmable pre-trigger portion. It then streams the frozen window, oldest sample first, to the display/readout logic over a valid/ready interface.

## Interface
- DATA_W, 14: sample width; two's-complement signed.
- ADDR_W, 10: buffer address width; DEPTH = 2**ADDR_W.
- clock  in  1  sole clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_W  signed sample from the front-end channel.
- sample_valid  in  1  sample_in is valid this cycle; may be high every cycle.
- out_of_range  in  1  front-end out-of-range flag, qualified by sample_valid.
- arm  in  1  single-cycle request to start a capture.
- abort  in  1  return to IDLE from any state.
- force_trig  in  1  manual trigger, honoured only in ARMED.
- trig_level  in  DATA_W  signed trigger threshold.
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- pretrig  in  ADDR_W  number of samples kept before the trigger sample.
- rd_data  out  DATA_W  readout sample.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  marks sample DEPTH-1 of the readout.
- busy  out  1  state != IDLE.
- triggered  out  1  trigger seen; high in POST and READ.
- ovr_seen  out  1  sticky: out_of_range occurred during the current capture.

## Operation
- States: IDLE, PRE, ARMED, POST, READ.
- IDLE -> PRE on arm; goes straight to ARMED if pretrig == 0. Arm also clears ovr_seen and the edge history.
- arm is ignored outside IDLE. abort wins over arm. abort from any state -> IDLE with pointers cleared; an in-progress readout is dropped.
- PRE, ARMED and POST: each valid sample is written at wr_ptr, then wr_ptr increments mod DEPTH. Wrap-around in ARMED is normal.
- PRE: counts pretrig valid samples, then moves to ARMED. pretrig is latched at arm; a value above DEPTH-1 is impossible by width.
- ARMED trigger detection:
  - Rising: prev < trig_level and cur >= trig_level.
  - Falling: prev >= trig_level and cur < trig_level.
  - Signed compare. prev is the previous valid sample since arm; there is no trigger on the first sample after arm.
- force_trig in ARMED: the next valid sample is treated as the trigger sample.
- Trigger sample: written, its address latched as trig_addr, state -> POST.
- POST: writes DEPTH-pretrig-1 further samples. With pretrig == DEPTH-1 it lasts 0 samples and moves straight to READ.
- READ: streams DEPTH samples starting at (trig_addr - pretrig) mod DEPTH, so the trigger sample is at readout index pretrig. sample_valid is ignored.
- After the rd_last handshake -> IDLE.
- ovr_seen is set by any out_of_range && sample_valid in PRE, ARMED or POST. It holds until the next arm or reset.

## Timing
- Reset values: state IDLE, rd_valid 0, rd_last 0, rd_data 0, busy 0, triggered 0, ovr_seen 0, pointers 0.
- arm at edge N: busy = 1 after edge N. The first sample written is the first valid sample at edge N+1 or later.
- Trigger evaluation is registered. triggered rises on the edge after the trigger sample is accepted.
- Entry to READ -> rd_valid high within 2 cycles (1-cycle RAM read latency plus output register).
- With rd_ready held high: 1 sample per cycle, no bubbles.
- rd_data, rd_valid and rd_last hold stable while rd_valid && !rd_ready.
- Last handshake at edge M: busy = 0 and rd_valid = 0 after edge M.
- Simultaneous trigger and abort: abort wins.
- Reset asserted mid-capture or mid-readout forces all reset values immediately.

## Structure
- Shared package: state encoding enum and default DATA_W/ADDR_W constants, reused by readout/display blocks.
- One sub-module: scope_sample_ram, a simple dual-port RAM (DATA_W × DEPTH, 1 write port, 1 registered read port) that infers M10K.
- The FSM, counters, trigger compare and readout skid register live in the top.

## Test plan
- DEPTH=1024, pretrig=256, rising, trig_level=0, ramp input -2000..+2000 step 1: trigger at the first sample ≥ 0. Readout index 256 = 0, index 0 = -256, rd_last at index 1023.
- Falling trigger, trig_level=100, samples 200, 150, 100, 99: trigger at 99. pretrig=0 gives readout[0] = 99.
- rd_ready toggling 1-0-1 on a random pattern: no sample lost or duplicated; data held stable during stalls. Exactly 1024 handshakes.
- force_trig in ARMED with a constant input of 5: capture completes, readout is all 5. pretrig=1023 gives an empty POST phase and the trigger sample at index 1023.
- abort during POST, then arm again: busy drops next cycle, the new capture is correct. arm pulsed during READ is ignored.
- out_of_range pulsed once in ARMED: ovr_seen = 1 through READ, 0 after the next arm. reset_n pulsed mid-READ gives all outputs at reset values.

Source files
------------

// File: rtl/scope_trigger_capture_pkg.sv
// Shared definitions for the scope capture path: default widths and the capture state encoding.
package scope_trigger_capture_pkg;

  localparam int CAP_DATA_W = 14;
  localparam int CAP_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } capState_t;

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port with read enable.
module scope_sample_ram
  import scope_trigger_capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clock,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset on the array or read register so the block maps onto a memory macro.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Trigger-and-capture stage: circular sample record, level/edge trigger, pre-trigger window,
// and oldest-first readout of the frozen window.
module scope_trigger_capture
  import scope_trigger_capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     out_of_range,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     force_trig,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic                     trig_rising,
  input  logic [ADDR_W-1:0]        pretrig,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     triggered,
  output logic                     ovr_seen,
  output capState_t                dbgState
);

  // Readout handshake: a sample transfers on a rising edge where rd_valid && rd_ready;
  // while rd_valid is high and rd_ready low, rd_data/rd_valid/rd_last do not change.

  capState_t state, stateNext;

  logic [ADDR_W-1:0]        wrPtr, rdPtr, pretrigLat, cnt;
  logic [ADDR_W:0]          issueCnt;
  logic signed [DATA_W-1:0] prevSample;
  logic                     prevValid, forcePend, memValid, memLast;
  logic [DATA_W-1:0]        ramQ;
  logic capturing, wrEn, edgeHit, trigHit, preDone, postDone, outFree, issue, lastHs;

  always_comb begin
    capturing = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
    wrEn      = capturing && sample_valid;
    if (trig_rising) edgeHit = prevValid && (prevSample < trig_level) && (sample_in >= trig_level);
    else             edgeHit = prevValid && (prevSample >= trig_level) && (sample_in < trig_level);
    trigHit   = (state == ST_ARMED) && sample_valid && (edgeHit || forcePend || force_trig);
    preDone   = (state == ST_PRE) && sample_valid && (cnt == pretrigLat - 1'b1);
    // Post-trigger length is DEPTH-1-pretrig, which is the bitwise complement of pretrig.
    postDone  = (state == ST_POST) && sample_valid && (cnt == ~pretrigLat - 1'b1);
    outFree   = !rd_valid || rd_ready;
    issue     = (state == ST_READ) && !issueCnt[ADDR_W] && (outFree || !memValid);
    lastHs    = rd_valid && rd_ready && rd_last;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (abort) begin
      stateNext = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm) stateNext = (pretrig == '0) ? ST_ARMED : ST_PRE;
        ST_PRE:   if (preDone) stateNext = ST_ARMED;
        ST_ARMED: if (trigHit) stateNext = (&pretrigLat) ? ST_READ : ST_POST;
        ST_POST:  if (postDone) stateNext = ST_READ;
        ST_READ:  if (lastHs) stateNext = ST_IDLE;
        default:  stateNext = ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign triggered = (state == ST_POST) || (state == ST_READ);
  assign dbgState  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      pretrigLat <= '0;
      cnt        <= '0;
      issueCnt   <= '0;
      prevSample <= '0;
      prevValid  <= 1'b0;
      forcePend  <= 1'b0;
      ovr_seen   <= 1'b0;
      memValid   <= 1'b0;
      memLast    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else if (abort) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      issueCnt  <= '0;
      prevValid <= 1'b0;
      forcePend <= 1'b0;
      memValid  <= 1'b0;
      memLast   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      if (state == ST_IDLE && arm) begin
        pretrigLat <= pretrig;
        cnt        <= '0;
        prevValid  <= 1'b0;
        forcePend  <= 1'b0;
        ovr_seen   <= 1'b0;
      end
      if (wrEn) begin
        wrPtr      <= wrPtr + 1'b1;
        prevSample <= sample_in;
        prevValid  <= 1'b1;
        if (out_of_range) ovr_seen <= 1'b1;
      end
      if (state == ST_PRE && sample_valid) cnt <= preDone ? '0 : cnt + 1'b1;
      if (state == ST_POST && sample_valid) cnt <= cnt + 1'b1;
      if (state == ST_ARMED && force_trig) forcePend <= 1'b1;
      // Oldest sample of the window sits pretrig slots behind the trigger sample.
      if (trigHit) begin
        rdPtr     <= wrPtr - pretrigLat;
        cnt       <= '0;
        forcePend <= 1'b0;
        issueCnt  <= '0;
      end
      if (issue) begin
        rdPtr    <= rdPtr + 1'b1;
        issueCnt <= issueCnt + 1'b1;
        memValid <= 1'b1;
        memLast  <= &issueCnt[ADDR_W-1:0];
      end else if (outFree) begin
        memValid <= 1'b0;
      end
      if (state == ST_READ && outFree) begin
        rd_valid <= memValid;
        rd_last  <= memValid && memLast;
        if (memValid) rd_data <= ramQ;
      end
    end
  end

  scope_sample_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock (clock),
    .wrEn  (wrEn),
    .wrAddr(wrPtr),
    .wrData(sample_in),
    .rdEn  (issue),
    .rdAddr(rdPtr),
    .rdData(ramQ)
  );

endmodule
